// File: rtl/alu_arith_pkg.sv
// Shared definitions for the 8051-style sequential arithmetic unit:
// opcode and state encodings, decimal-adjust constants and addend selection.
package alu_arith_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDC = 3'b001,
    OP_SUBB = 3'b010,
    OP_INC  = 3'b011,
    OP_DEC  = 3'b100,
    OP_DA   = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam logic [7:0] DA_LO_ADJ = 8'h06;
  localparam logic [7:0] DA_HI_ADJ = 8'h60;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  // Flag write-enable patterns, ordered {CY, AC, OV}
  localparam logic [2:0] WE_ALL  = 3'b111;
  localparam logic [2:0] WE_CY   = 3'b100;
  localparam logic [2:0] WE_NONE = 3'b000;

  function automatic logic [7:0] da_lo_addend(input logic [7:0] v, input logic ac);
    return ((v[3:0] > BCD_MAX) || ac) ? DA_LO_ADJ : 8'h00;
  endfunction

  function automatic logic [7:0] da_hi_addend(input logic [7:0] v, input logic cy);
    return ((v[7:4] > BCD_MAX) || cy) ? DA_HI_ADJ : 8'h00;
  endfunction

endpackage

// File: rtl/alu_arith_seq_if.sv
// Request/response bundle between an instruction sequencer (master) and the
// arithmetic unit (slave).
interface alu_arith_seq_if;

  logic       start;
  logic [2:0] op;
  logic [7:0] acc_in;
  logic [7:0] opnd_in;
  logic       cy_in;
  logic       ac_in;

  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cy;
  logic       ac;
  logic       ov;
  logic [2:0] flag_we;

  modport master (
    output start, op, acc_in, opnd_in, cy_in, ac_in,
    input  busy, done, result, cy, ac, ov, flag_we
  );

  modport slave (
    input  start, op, acc_in, opnd_in, cy_in, ac_in,
    output busy, done, result, cy, ac, ov, flag_we
  );

endinterface

// File: rtl/adder_8051.sv
// 8-bit adder producing the 8051 flag sources: carry out, carry out of bit 3
// (half carry) and signed overflow (carry into bit 7 xor carry out of bit 7).
module adder_8051 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] sum,
  output logic       co,
  output logic       hco,
  output logic       ovo
);

  logic [4:0] lo;
  logic [3:0] mid;
  logic [1:0] hi;

  // Split at bit 3 and bit 6 so the half carry and the carry into the sign
  // bit come out directly.
  always_comb begin
    lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, ci};
    mid = {1'b0, a[6:4]} + {1'b0, b[6:4]} + {3'b000, lo[4]};
    hi  = {1'b0, a[7]}   + {1'b0, b[7]}   + {1'b0, mid[3]};
    sum = {hi[0], mid[2:0], lo[3:0]};
    co  = hi[1];
    hco = lo[4];
    ovo = hi[1] ^ mid[3];
  end

endmodule

// File: rtl/alu_arith_seq.sv
// Sequential 8051 arithmetic unit: ADD/ADDC/SUBB/INC/DEC in one adder pass,
// DA in two passes, all through a single shared adder.
module alu_arith_seq
  import alu_arith_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_arith_seq_if.slave bus
);

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       cyl_q, cyl_d;
  logic       acl_q, acl_d;
  logic [7:0] tmp_q, tmp_d;

  logic [7:0] result_q, result_d;
  logic       cy_q, cy_d;
  logic       ac_q, ac_d;
  logic       ov_q, ov_d;
  logic [2:0] flag_we_q, flag_we_d;

  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_ci;
  logic [7:0] add_sum;
  logic       add_co;
  logic       add_hco;
  logic       add_ovo;

  adder_8051 u_adder_8051 (
    .a   (add_a),
    .b   (add_b),
    .ci  (add_ci),
    .sum (add_sum),
    .co  (add_co),
    .hco (add_hco),
    .ovo (add_ovo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 3'b000;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      cyl_q     <= 1'b0;
      acl_q     <= 1'b0;
      tmp_q     <= 8'h00;
      result_q  <= 8'h00;
      cy_q      <= 1'b0;
      ac_q      <= 1'b0;
      ov_q      <= 1'b0;
      flag_we_q <= WE_NONE;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cyl_q     <= cyl_d;
      acl_q     <= acl_d;
      tmp_q     <= tmp_d;
      result_q  <= result_d;
      cy_q      <= cy_d;
      ac_q      <= ac_d;
      ov_q      <= ov_d;
      flag_we_q <= flag_we_d;
    end
  end

  // Visible outputs only change on the transition into FIN, so they hold
  // from one completed operation to the next.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cyl_d     = cyl_q;
    acl_d     = acl_q;
    tmp_d     = tmp_q;
    result_d  = result_q;
    cy_d      = cy_q;
    ac_d      = ac_q;
    ov_d      = ov_q;
    flag_we_d = flag_we_q;
    add_a     = a_q;
    add_b     = 8'h00;
    add_ci    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_d     = bus.acc_in;
          b_d     = bus.opnd_in;
          cyl_d   = bus.cy_in;
          acl_d   = bus.ac_in;
          state_d = ST_PASS1;
        end
      end

      ST_PASS1: begin
        // Illegal opcodes fall through with A+0, which returns ACC unchanged.
        case (op_q)
          OP_ADD:  add_b = b_q;
          OP_ADDC: begin add_b = b_q;  add_ci = cyl_q;  end
          OP_SUBB: begin add_b = ~b_q; add_ci = ~cyl_q; end
          OP_INC:  add_ci = 1'b1;
          OP_DEC:  add_b = 8'hFF;
          OP_DA:   add_b = da_lo_addend(a_q, acl_q);
          default: add_b = 8'h00;
        endcase

        if (op_q == OP_DA) begin
          tmp_d   = add_sum;
          cyl_d   = cyl_q | add_co;
          state_d = ST_PASS2;
        end else begin
          result_d  = add_sum;
          cy_d      = 1'b0;
          ac_d      = 1'b0;
          ov_d      = 1'b0;
          flag_we_d = WE_NONE;
          case (op_q)
            OP_ADD, OP_ADDC: begin
              cy_d      = add_co;
              ac_d      = add_hco;
              ov_d      = add_ovo;
              flag_we_d = WE_ALL;
            end
            OP_SUBB: begin
              cy_d      = ~add_co;
              ac_d      = ~add_hco;
              ov_d      = add_ovo;
              flag_we_d = WE_ALL;
            end
            default: flag_we_d = WE_NONE;
          endcase
          state_d = ST_FIN;
        end
      end

      ST_PASS2: begin
        add_a     = tmp_q;
        add_b     = da_hi_addend(tmp_q, cyl_q);
        result_d  = add_sum;
        cy_d      = cyl_q | add_co;
        ac_d      = 1'b0;
        ov_d      = 1'b0;
        flag_we_d = WE_CY;
        state_d   = ST_FIN;
      end

      ST_FIN: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_FIN);
  assign bus.result  = result_q;
  assign bus.cy      = cy_q;
  assign bus.ac      = ac_q;
  assign bus.ov      = ov_q;
  assign bus.flag_we = flag_we_q;

endmodule

// File: tb/tb_alu_arith_seq.sv
// Randomized and directed bench for alu_arith_seq against a transaction-level
// arithmetic model with a cycle countdown for timing.
module tb_alu_arith_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_arith_seq_if bus ();

  alu_arith_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         rem = 0;
  logic [7:0] m_res = 8'h00, p_res = 8'h00;
  logic       m_cy = 1'b0, m_ac = 1'b0, m_ov = 1'b0;
  logic       p_cy = 1'b0, p_ac = 1'b0, p_ov = 1'b0;
  logic [2:0] m_we = 3'b000, p_we = 3'b000;
  int         p_passes = 1;

  function automatic int sx(input logic [7:0] v);
    return v[7] ? int'(v) - 256 : int'(v);
  endfunction

  function automatic void ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic ain,
                                 output logic [7:0] r, output logic cy, output logic ac,
                                 output logic ov, output logic [2:0] we, output int passes);
    int s, h, v, c;
    r = a; cy = 1'b0; ac = 1'b0; ov = 1'b0; we = 3'b000; passes = 1;
    case (op)
      3'd0, 3'd1: begin
        c  = (op == 3'd1) ? int'(cin) : 0;
        s  = int'(a) + int'(b) + c;
        h  = int'(a[3:0]) + int'(b[3:0]) + c;
        v  = sx(a) + sx(b) + c;
        r  = s[7:0];
        cy = (s > 255);
        ac = (h > 15);
        ov = (v > 127) || (v < -128);
        we = 3'b111;
      end
      3'd2: begin
        c  = int'(cin);
        s  = int'(a) - int'(b) - c;
        h  = int'(a[3:0]) - int'(b[3:0]) - c;
        v  = sx(a) - sx(b) - c;
        r  = s[7:0];
        cy = (s < 0);
        ac = (h < 0);
        ov = (v > 127) || (v < -128);
        we = 3'b111;
      end
      3'd3: begin s = int'(a) + 1; r = s[7:0]; end
      3'd4: begin s = int'(a) - 1; r = s[7:0]; end
      3'd5: begin
        v = int'(a);
        c = int'(cin);
        if ((int'(a[3:0]) > 9) || ain) begin
          v = v + 6;
          if (v > 255) c = 1;
          v = v % 256;
        end
        if (((v / 16) > 9) || (c != 0)) begin
          v = v + 96;
          if (v > 255) c = 1;
          v = v % 256;
        end
        r      = v[7:0];
        cy     = (c != 0);
        we     = 3'b100;
        passes = 2;
      end
      default: r = a;
    endcase
  endfunction

  // rem counts edges until the unit is idle again; outputs appear when it reaches 1
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      rem = 0;
      m_res = 8'h00; m_cy = 1'b0; m_ac = 1'b0; m_ov = 1'b0; m_we = 3'b000;
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 1) begin
        m_res = p_res; m_cy = p_cy; m_ac = p_ac; m_ov = p_ov; m_we = p_we;
      end
    end else if (bus.start) begin
      ref_op(bus.op, bus.acc_in, bus.opnd_in, bus.cy_in, bus.ac_in,
             p_res, p_cy, p_ac, p_ov, p_we, p_passes);
      rem = p_passes + 1;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("busy",    8'(bus.busy),    8'(rem > 0));
    check("done",    8'(bus.done),    8'(rem == 1));
    check("result",  bus.result,      m_res);
    check("cy",      8'(bus.cy),      8'(m_cy));
    check("ac",      8'(bus.ac),      8'(m_ac));
    check("ov",      8'(bus.ov),      8'(m_ov));
    check("flag_we", 8'(bus.flag_we), 8'(m_we));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic h);
    @(posedge clk); #1;
    bus.op = op; bus.acc_in = a; bus.opnd_in = b; bus.cy_in = c; bus.ac_in = h;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] r;
    logic       fc, fa, fo;
    logic [2:0] fw;
    int         p, lat, nd;
    logic [7:0] inc_res;
    logic [2:0] inc_we;

    bus.start = 1'b0; bus.op = 3'b000; bus.acc_in = 8'h00; bus.opnd_in = 8'h00;
    bus.cy_in = 1'b0; bus.ac_in = 1'b0;

    // hand-computed pins on the model itself
    ref_op(3'd0, 8'h7F, 8'h01, 1'b0, 1'b0, r, fc, fa, fo, fw, p);
    check("model_add_res", r, 8'h80);
    check("model_add_flags", {5'b0, fc, fa, fo}, 8'b011);
    ref_op(3'd2, 8'h00, 8'h01, 1'b0, 1'b0, r, fc, fa, fo, fw, p);
    check("model_subb_res", r, 8'hFF);
    check("model_subb_flags", {5'b0, fc, fa, fo}, 8'b110);
    ref_op(3'd5, 8'hBD, 8'h00, 1'b0, 1'b0, r, fc, fa, fo, fw, p);
    check("model_da_res", r, 8'h23);
    check("model_da_cy_passes", {fc, 7'(p)}, {1'b1, 7'd2});

    // cold reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", 8'(bus.busy), 8'h00);
    check("rst_done", 8'(bus.done), 8'h00);
    check("rst_result", bus.result, 8'h00);
    check("rst_flags", {4'b0, bus.cy, bus.ac, bus.ov, 1'b0}, 8'h00);
    check("rst_flag_we", 8'(bus.flag_we), 8'h00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // ADD 0x7F + 0x01
    drive(3'b000, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    check("add_latency", 8'(lat), 8'd2);
    check("add_result", bus.result, 8'h80);
    check("add_flags", {5'b0, bus.cy, bus.ac, bus.ov}, 8'b011);
    check("add_flag_we", 8'(bus.flag_we), 8'b111);

    // DA 0xBD
    drive(3'b101, 8'hBD, 8'h00, 1'b0, 1'b0);
    wait_done(lat);
    check("da_latency", 8'(lat), 8'd3);
    check("da_result", bus.result, 8'h23);
    check("da_cy", 8'(bus.cy), 8'h01);
    check("da_flag_we", 8'(bus.flag_we), 8'b100);

    // INC 0xFF with START held across the next edge
    @(posedge clk); #1;
    bus.op = 3'b011; bus.acc_in = 8'hFF; bus.opnd_in = 8'h00; bus.cy_in = 1'b1; bus.ac_in = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    nd = 0; inc_res = 8'hAA; inc_we = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        nd++;
        inc_res = bus.result;
        inc_we  = bus.flag_we;
      end
    end
    check("inc_done_count", 8'(nd), 8'd1);
    check("inc_result", inc_res, 8'h00);
    check("inc_flag_we", 8'(inc_we), 8'b000);

    // DEC 0x00 wraps to 0xFF
    drive(3'b100, 8'h00, 8'h55, 1'b0, 1'b0);
    wait_done(lat);
    check("dec_latency", 8'(lat), 8'd2);
    check("dec_result", bus.result, 8'hFF);

    // SUBB 0x00 - 0x01, borrow in 0
    drive(3'b010, 8'h00, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    check("subb_result", bus.result, 8'hFF);
    check("subb_flags", {5'b0, bus.cy, bus.ac, bus.ov}, 8'b110);

    // reset while DA is in its second pass
    drive(3'b101, 8'h9A, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("mid_busy", 8'(bus.busy), 8'h01);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 8'(bus.busy), 8'h00);
    check("abort_done", 8'(bus.done), 8'h00);
    check("abort_result", bus.result, 8'h00);
    check("abort_flags", {5'b0, bus.cy, bus.ac, bus.ov}, 8'h00);
    check("abort_flag_we", 8'(bus.flag_we), 8'h00);
    @(posedge clk); #3;
    rst_n = 1'b1;
    count_done(4, nd);
    check("abort_no_done", 8'(nd), 8'd0);

    drive(3'b000, 8'h01, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    check("post_rst_latency", 8'(lat), 8'd2);
    check("post_rst_result", bus.result, 8'h02);

    // illegal opcodes pass ACC through
    drive(3'b111, 8'h5A, 8'hC3, 1'b1, 1'b1);
    wait_done(lat);
    check("ill7_latency", 8'(lat), 8'd2);
    check("ill7_result", bus.result, 8'h5A);
    check("ill7_flag_we", 8'(bus.flag_we), 8'b000);
    drive(3'b110, 8'hA5, 8'h3C, 1'b0, 1'b0);
    wait_done(lat);
    check("ill6_result", bus.result, 8'hA5);

    // ADDC with carry in: 0x0F + 0xF0 + 1 = 0x100
    drive(3'b001, 8'h0F, 8'hF0, 1'b1, 1'b0);
    wait_done(lat);
    check("addc_result", bus.result, 8'h00);
    check("addc_flags", {5'b0, bus.cy, bus.ac, bus.ov}, 8'b110);

    // randomized traffic, including START while busy and occasional async resets
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      bus.op      = 3'($urandom_range(0, 7));
      bus.acc_in  = 8'($urandom);
      bus.opnd_in = 8'($urandom);
      bus.cy_in   = 1'($urandom);
      bus.ac_in   = 1'($urandom);
      bus.start   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arith_seq.md
ALU_ARITH_SEQ -- requirements
Module: alu_arith_seq

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameters: none.
REQ-003 CLK  input  1  system clock, rising-edge active.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 START  input  1  request strobe, sampled only in IDLE.
REQ-006 OP  input  3  operation: 000 ADD, 001 ADDC, 010 SUBB, 011 INC, 100 DEC, 101 DA; 110/111 illegal.
REQ-007 ACC_IN  input  8  accumulator operand.
REQ-008 OPND_IN  input  8  second operand; ignored for INC/DEC/DA.
REQ-009 CY_IN  input  1  current PSW carry.
REQ-010 AC_IN  input  1  current PSW aux carry.
REQ-011 BUSY  output  1  high whenever state is not IDLE.
REQ-012 DONE  output  1  one-cycle pulse; RESULT/flags valid.
REQ-013 RESULT  output  8  registered result.
REQ-014 CY, AC, OV  output  1 each  registered flag results.
REQ-015 FLAG_WE  output  3  flag write enables {CY,AC,OV}, valid with DONE.

Function
REQ-016 FSM states SHALL be IDLE, PASS1, PASS2, FIN.
REQ-017 In IDLE, START=1 at edge N SHALL latch OP, ACC_IN, OPND_IN, CY_IN, AC_IN and enter PASS1.
REQ-018 PASS1 SHALL drive the shared adder from latched operands and register RESULT and flags at the end of the cycle.
REQ-019 ADD: A+B, CI=0; ADDC: A+B, CI=CY_IN; CY=CO, AC=HCO, OV=OVO; FLAG_WE=111.
REQ-020 SUBB: A+~B, CI=~CY_IN; CY=~CO, AC=~HCO, OV=OVO; FLAG_WE=111.
REQ-021 INC: A+0x00, CI=1; DEC: A+0xFF, CI=0; FLAG_WE=000; wrap 0xFF->0x00 and 0x00->0xFF.
REQ-022 DA PASS1: add 0x06 if A[3:0]>9 or AC_IN, else add 0x00; carry-out ORed into latched CY.
REQ-023 DA PASS2: add 0x60 to PASS1 result if its [7:4]>9 or latched CY is 1, else add 0x00; CY = latched CY OR carry-out; FLAG_WE=100.
REQ-024 Illegal OP: RESULT=ACC_IN, FLAG_WE=000, normal single-pass timing.
REQ-025 Non-DA: PASS1->FIN. DA: PASS1->PASS2->FIN. FIN->IDLE unconditionally.
REQ-026 DONE SHALL be high exactly in FIN. Latency from START edge N: DONE at N+2 for single-pass ops, N+3 for DA.
REQ-027 START while BUSY (including FIN) SHALL be ignored. Earliest accepted follow-on START is the cycle after FIN.
REQ-028 RESULT, CY, AC, OV, FLAG_WE SHALL hold their values until the next FIN.
REQ-029 Flags with FLAG_WE bit 0 SHALL output 0.

Reset
REQ-030 RST_N low SHALL force IDLE and set BUSY, DONE, RESULT, CY, AC, OV and FLAG_WE to 0 immediately, regardless of the clock.
REQ-031 Reset mid-operation SHALL abort the operation with no DONE pulse. The first START after release SHALL behave as from cold.

Structure
REQ-032 Shared package alu_arith_pkg SHALL hold the OP encodings, state encoding, and DA constants 0x06/0x60.
REQ-033 Exactly one ADDER_8051 instance SHALL be used for all passes; no other adders are permitted.

Verification
REQ-034 ADD ACC=0x7F, OPND=0x01 -> RESULT 0x80, CY0 AC1 OV1, FLAG_WE 111, DONE at N+2.
REQ-035 SUBB ACC=0x00, OPND=0x01, CY_IN=0 -> RESULT 0xFF, CY1 AC1 OV0.
REQ-036 DA ACC=0xBD, AC_IN=0, CY_IN=0 -> RESULT 0x23, CY1, FLAG_WE 100, DONE at N+3.
REQ-037 INC ACC=0xFF, with START re-pulsed at N+1 -> RESULT 0x00, FLAG_WE 000, exactly one DONE.
REQ-038 RST_N low during PASS2 of DA -> all outputs 0 at once, no DONE. Then ADD 0x01+0x01 -> 0x02.
REQ-039 OP=111, ACC=0x5A -> RESULT 0x5A, FLAG_WE 000, DONE at N+2.
